// File: rtl/cfg_seq_pkg.sv
// Shared types and sizing helpers for the configuration-chain load sequencer.
package cfg_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_e;

    localparam int unsigned CHAIN_LEN_DEF = 96;
    localparam int unsigned WORD_W_DEF    = 8;
    localparam int unsigned CLK_DIV_DEF   = 1;

    // Width of a counter that must hold the value n itself.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cfg_load_sequencer_if.sv
// Host-side bitstream write stream and readback strobe of the load sequencer.
interface cfg_load_sequencer_if #(
    parameter int unsigned WORD_W = 8
);
    logic [WORD_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_data, wr_valid,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_data, wr_valid,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/cfg_clk_div.sv
// Half-period counter: tick on the CLK_DIV-th cycle since the last clear.
module cfg_clk_div
    import cfg_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CW = cnt_w(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/cfg_load_sequencer.sv
// Serializes host words onto the fabric prog_en/prog_in/prog_clk chain.
// Define CFG_READBACK_EN to capture the previous chain contents from prog_out.
module cfg_load_sequencer
    import cfg_seq_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned CLK_DIV   = CLK_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    cfg_load_sequencer_if.slave  bus,
    output logic                 prog_clk,
    output logic                 prog_en,
    output logic                 prog_in,
    input  logic                 prog_out,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned BW = cnt_w(CHAIN_LEN);
    localparam int unsigned IW = cnt_w(WORD_W);

    state_e            state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]     bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0] word_q, word_d, word_sh;
    logic              prog_clk_q, prog_clk_d;
    logic              prog_en_q, prog_en_d;
    logic              prog_in_q, prog_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick, xfer, last_bit, last_idx;

    assign bus.wr_ready = (state_q == LOAD) && !abort;
    assign xfer         = bus.wr_valid && bus.wr_ready;
    assign last_bit     = (bit_cnt_q == BW'(CHAIN_LEN - 1));
    assign last_idx     = (bit_idx_q == IW'(WORD_W - 1));

    cfg_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_d != state_q),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        word_d    = word_q;
        prog_in_d = prog_in_q;
        word_sh   = '0;
        unique case (state_q)
            IDLE: if (start) begin
                state_d   = LOAD;
                bit_cnt_d = '0;
                bit_idx_d = '0;
            end
            LOAD: if (xfer) begin
                word_d    = bus.wr_data;
                bit_idx_d = '0;
                state_d   = SHIFT_LO;
            end
            SHIFT_LO: if (tick) state_d = SHIFT_HI;
            SHIFT_HI: if (tick) begin
                bit_cnt_d = bit_cnt_q + BW'(1);
                if (last_bit)      state_d = DONE;
                else if (last_idx) state_d = LOAD;
                else begin
                    bit_idx_d = bit_idx_q + IW'(1);
                    state_d   = SHIFT_LO;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;

        // Outputs are registered from the next state so they stay glitch-free.
        word_sh    = word_d >> bit_idx_d;
        if (state_d == SHIFT_LO) prog_in_d = word_sh[0];
        prog_clk_d = (state_d == SHIFT_HI);
        prog_en_d  = (state_d == LOAD) || (state_d == SHIFT_LO) ||
                     (state_d == SHIFT_HI);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            word_q     <= '0;
            prog_clk_q <= 1'b0;
            prog_en_q  <= 1'b0;
            prog_in_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            word_q     <= word_d;
            prog_clk_q <= prog_clk_d;
            prog_en_q  <= prog_en_d;
            prog_in_q  <= prog_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign prog_clk = prog_clk_q;
    assign prog_en  = prog_en_q;
    assign prog_in  = prog_in_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef CFG_READBACK_EN
    logic [WORD_W-1:0] acc_q, acc_d, rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    // prog_out is sampled just before each rising edge, i.e. old contents.
    always_comb begin
        acc_d      = acc_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (state_q == SHIFT_LO && tick && !abort) begin
            acc_d = acc_q | (WORD_W'(prog_out) << bit_idx_q);
            if (last_idx || last_bit) begin
                rd_data_d  = acc_d;
                rd_valid_d = 1'b1;
                acc_d      = '0;
            end
        end
        if (state_q == IDLE) acc_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`else
    logic unused_prog_out;
    assign unused_prog_out = prog_out;
    assign bus.rd_data     = '0;
    assign bus.rd_valid    = 1'b0;
`endif
endmodule

// File: tb/tb_cfg_load_sequencer.sv
// Scoreboard bench: two sequencers (CLK_DIV 1 and 3) against a 12-bit chain model.
module tb_cfg_load_sequencer;
    localparam int CL = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_a [2] = '{default: 1'b0};
    logic       abort_a [2] = '{default: 1'b0};
    logic [7:0] wr_data_a [2] = '{default: '0};
    logic       wr_valid_a [2] = '{default: 1'b0};
    logic       wr_ready_a [2];
    logic [7:0] rd_data_a [2];
    logic       rd_valid_a [2];
    logic       prog_clk_a [2], prog_en_a [2], prog_in_a [2];
    logic       prog_out_a [2], busy_a [2], done_a [2];
    logic [CL-1:0] chain [2] = '{default: '0};

    for (genvar g = 0; g < 2; g++) begin : u
        cfg_load_sequencer_if #(.WORD_W(8)) bus ();
        assign bus.wr_data    = wr_data_a[g];
        assign bus.wr_valid   = wr_valid_a[g];
        assign wr_ready_a[g]  = bus.wr_ready;
        assign rd_data_a[g]   = bus.rd_data;
        assign rd_valid_a[g]  = bus.rd_valid;
        assign prog_out_a[g]  = chain[g][0];
        cfg_load_sequencer #(
            .CHAIN_LEN (CL),
            .WORD_W    (8),
            .CLK_DIV   ((g == 0) ? 1 : 3)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start_a[g]),
            .abort    (abort_a[g]),
            .bus      (bus),
            .prog_clk (prog_clk_a[g]),
            .prog_en  (prog_en_a[g]),
            .prog_in  (prog_in_a[g]),
            .prog_out (prog_out_a[g]),
            .busy     (busy_a[g]),
            .done     (done_a[g])
        );
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm, input int v);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event (value %0d)", nm, v);
    endtask

    bit            exp_bits [$];
    logic [CL-1:0] exp_chain [$];
    logic [7:0]    exp_rd [$];

    int   edge_cnt [2] = '{default: 0};
    int   low_run [2]  = '{default: 0};
    int   high_run [2] = '{default: 0};
    logic prev_clk [2] = '{default: 1'b0};
    logic hi_in [2]    = '{default: 1'b0};
    int   div_v [2]    = '{1, 3};
    bit   lvl_en = 1'b1;

    // Monitor: chain model, prog_in scoreboard, level timing, done, readback.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!rst) begin
                if (prog_clk_a[s] && !prev_clk[s]) begin
                    edge_cnt[s]++;
                    chk("en_at_rise", prog_en_a[s], 1);
                    if (exp_bits.size() == 0) bad("extra_edge", edge_cnt[s]);
                    else chk("prog_in", prog_in_a[s], exp_bits.pop_front());
                    if (lvl_en) chk("lo_len", low_run[s], div_v[s]);
                    chain[s] = {prog_in_a[s], chain[s][CL-1:1]};
                    hi_in[s] = prog_in_a[s];
                    low_run[s] = 0;
                end
                if (prog_clk_a[s] && prev_clk[s])
                    chk("in_stable", prog_in_a[s], hi_in[s]);
                if (!prog_clk_a[s] && prev_clk[s]) begin
                    if (lvl_en) chk("hi_len", high_run[s], div_v[s]);
                    high_run[s] = 0;
                end
                if (prog_clk_a[s]) high_run[s]++;
                else if (prog_en_a[s] && !wr_ready_a[s]) low_run[s]++;
                if (done_a[s]) begin
                    if (exp_chain.size() == 0) bad("extra_done", s);
                    else begin
                        chk("chain", chain[s], exp_chain.pop_front());
                        chk("edges", edge_cnt[s], CL);
                        chk("done_en", prog_en_a[s], 0);
                        chk("done_clk", prog_clk_a[s], 0);
                    end
                end
                if (rd_valid_a[s]) begin
`ifdef CFG_READBACK_EN
                    if (exp_rd.size() == 0) bad("extra_rd", s);
                    else chk("rd_data", rd_data_a[s], exp_rd.pop_front());
`else
                    bad("rd_valid", s);
`endif
                end
                if (!busy_a[s]) begin
                    edge_cnt[s] = 0;
                    low_run[s] = 0;
                    high_run[s] = 0;
                end
            end
            prev_clk[s] = prog_clk_a[s];
        end
    end

    task automatic pulse_start(input int s);
        @(posedge clk); #1 start_a[s] = 1'b1;
        @(posedge clk); #1 start_a[s] = 1'b0;
    endtask

    task automatic send(input int s, input logic [7:0] w, input int gap);
        int t = 0;
        @(negedge clk);
        while (!wr_ready_a[s]) begin
            if (t++ > 300) begin
                bad("ready_timeout", s);
                return;
            end
            @(negedge clk);
        end
        repeat (gap) begin
            chk("gap_clk", prog_clk_a[s], 0);
            chk("gap_en", prog_en_a[s], 1);
            @(negedge clk);
        end
        wr_data_a[s]  = w;
        wr_valid_a[s] = 1'b1;
        @(posedge clk); #1 wr_valid_a[s] = 1'b0;
    endtask

    task automatic load(input int s, input logic [CL-1:0] v,
                        input int gap, input bit restart);
        int t = 0;
        for (int i = 0; i < CL; i++) exp_bits.push_back(v[i]);
        exp_chain.push_back(v);
`ifdef CFG_READBACK_EN
        exp_rd.push_back(chain[s][7:0]);
        exp_rd.push_back({4'h0, chain[s][CL-1:8]});
`endif
        pulse_start(s);
        send(s, v[7:0], 0);
        if (restart) pulse_start(s);
        send(s, {4'($urandom), v[CL-1:8]}, gap);
        do begin
            @(negedge clk);
            if (t++ > 400) begin
                bad("done_timeout", s);
                return;
            end
        end while (!done_a[s]);
        @(negedge clk);
        chk("busy_after", busy_a[s], 0);
        chk("done_once", done_a[s], 0);
        chk("ready_idle", wr_ready_a[s], 0);
    endtask

    task automatic chk_zero(input string nm, input int s);
        chk({nm, "_clk"}, prog_clk_a[s], 0);
        chk({nm, "_en"}, prog_en_a[s], 0);
        chk({nm, "_in"}, prog_in_a[s], 0);
        chk({nm, "_busy"}, busy_a[s], 0);
        chk({nm, "_done"}, done_a[s], 0);
        chk({nm, "_ready"}, wr_ready_a[s], 0);
        chk({nm, "_rdv"}, rd_valid_a[s], 0);
        chk({nm, "_rdd"}, rd_data_a[s], 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int t;
        logic [CL-1:0] v;
        repeat (2) @(negedge clk);
        chk_zero("reset", 0);
        chk_zero("reset", 1);
        @(posedge clk); #1 rst = 1'b0;

        load(0, 12'h3A5, 0, 1'b0);
        load(0, 12'h3A5, 5, 1'b0);
        load(0, 12'h000, 0, 1'b0);

        // Abort after six rising edges.
        lvl_en = 1'b0;
        v = 12'($urandom);
        for (int i = 0; i < 6; i++) exp_bits.push_back(v[i]);
        pulse_start(0);
        send(0, v[7:0], 0);
        hi = 0;
        t = 0;
        while (hi < 6 && t < 200) begin
            @(negedge clk);
            if (prog_clk_a[0]) hi++;
            t++;
        end
        chk("abort_edges_seen", hi, 6);
        @(posedge clk); #1 abort_a[0] = 1'b1;
        @(posedge clk); #1 abort_a[0] = 1'b0;
        @(negedge clk);
        chk("abort_en", prog_en_a[0], 0);
        chk("abort_clk", prog_clk_a[0], 0);
        chk("abort_busy", busy_a[0], 0);
        repeat (6) @(negedge clk);
        chk("abort_left", exp_bits.size(), 0);
        lvl_en = 1'b1;
        load(0, 12'($urandom), 0, 1'b0);

        // Asynchronous reset in the middle of a high phase.
        lvl_en = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits.push_back(1'b1);
        pulse_start(0);
        send(0, 8'hFF, 0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!prog_clk_a[0] && t < 100);
        chk("rst_hi_seen", prog_clk_a[0], 1);
        #1 rst = 1'b1;
        start_a[0] = 1'b1;
        #1 chk_zero("async_rst", 0);
        @(posedge clk); #1;
        exp_bits.delete();
        start_a[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy_a[0], 0);
        chk("post_rst_en", prog_en_a[0], 0);
        repeat (2) @(negedge clk);
        chk("post_rst_idle", busy_a[0], 0);
        lvl_en = 1'b1;

        load(1, 12'h3A5, 0, 1'b1);
        load(1, 12'($urandom), 2, 1'b1);

        for (int i = 0; i < 6; i++) begin
            load(int'($urandom_range(0, 1)), 12'($urandom),
                 int'($urandom_range(0, 4)), 1'($urandom));
        end

        repeat (4) @(negedge clk);
        chk("bits_left", exp_bits.size(), 0);
        chk("chain_left", exp_chain.size(), 0);
        chk("rd_left", exp_rd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
